// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//
// Purpose:
//   Serialises one byte at a time onto an asynchronous serial line as
//   start bit (0), eight data bits LSB first, optional even-parity bit and
//   stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles. Bytes are
//   taken from the read side of an upstream FIFO with a valid/enable
//   handshake. After every frame at least one IDLE cycle is spent, which is
//   the cycle that carries the tx_done pulse.
//
// Configuration:
//   UART_TX_PARITY_EN - when defined, a PARITY state follows DATA and sends
//                       the XOR of the eight data bits (even parity). When
//                       undefined, DATA goes straight to STOP.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit, 2..65535
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset; aborts any frame in flight
//   data_in       byte offered by the FIFO
//   input_valid   data_in holds a valid byte (FIFO output_valid)
//   input_enable  ready to accept a byte (FIFO output_enable); high only in
//                 IDLE while rst is low
//   tx            serial output, idle high
//   busy          high while a frame is in progress
//   tx_done       one-cycle pulse in the first IDLE cycle after STOP
// -----------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       input_valid,
    output logic       input_enable,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // Explicit encodings keep the remaining states stable whether or not
    // the parity state is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic accept;
    logic bit_end;

    // Ready depends only on the registered state and reset, never on
    // input_valid, so the FIFO sees no combinational loop through us.
    assign input_enable = (state_q == IDLE) && !rst;
    assign accept       = input_valid && input_enable;
    assign bit_end      = (timer_q == LAST_TICK);

    assign tx      = tx_q;
    assign busy    = (state_q != IDLE);
    assign tx_done = tx_done_q;

    // tx is registered: tx_d is computed for the state being entered so the
    // line changes exactly on the edge where the state changes.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                if (accept) begin
                    state_d = START;
                    shift_d = data_in;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    // Captured on accept because the shift register is
                    // consumed while the data bits go out.
                    parity_d = ^data_in;
`endif
                end
            end

            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    timer_d   = '0;
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    tx_done_d = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_byte
//
// Directed bench for uart_tx_byte with CLKS_PER_BIT=4. Frames are given as
// hand-written bit sequences, index 0 = first bit on the line. Works with or
// without UART_TX_PARITY_EN defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_byte;

    localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    // {stop, parity, d7..d0, start}
    localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] F_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] F_FF = 11'b1_0_11111111_0;
    localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] F_5A = 11'b1_0_01011010_0;
    localparam logic [10:0] F_81 = 11'b1_0_10000001_0;
`else
    localparam int NB = 10;
    // {unused, stop, d7..d0, start}
    localparam logic [10:0] F_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] F_00 = 11'b0_1_00000000_0;
    localparam logic [10:0] F_FF = 11'b0_1_11111111_0;
    localparam logic [10:0] F_3C = 11'b0_1_00111100_0;
    localparam logic [10:0] F_5A = 11'b0_1_01011010_0;
    localparam logic [10:0] F_81 = 11'b0_1_10000001_0;
`endif

    localparam int FRAME = NB * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       input_valid;
    logic       input_enable;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_log[$];

    uart_tx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .input_valid  (input_valid),
        .input_enable (input_enable),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timestamp every handshake edge.
    always @(posedge clk) begin
        if (input_valid === 1'b1 && input_enable === 1'b1)
            acc_log.push_back(cyc);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Offers byte b, then checks every
    // cycle of the frame and the tx_done cycle. Returns at the negedge of the
    // first IDLE cycle, so a following call is accepted back-to-back.
    task automatic play_frame(input string tag, input logic [7:0] b, input logic [10:0] seq,
                              input bit hold_valid, input bit toggle_data);
        data_in     = b;
        input_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) input_valid = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            check($sformatf("%s tx c%0d", tag, c), tx, seq[(c - 1) / CPB]);
            check($sformatf("%s busy c%0d", tag, c), busy, 1'b1);
            check($sformatf("%s ie c%0d", tag, c), input_enable, 1'b0);
            check($sformatf("%s done c%0d", tag, c), tx_done, 1'b0);
            if (toggle_data) data_in = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        check($sformatf("%s done_pulse", tag), tx_done, 1'b1);
        check($sformatf("%s busy_end", tag), busy, 1'b0);
        check($sformatf("%s tx_end", tag), tx, 1'b1);
        check($sformatf("%s ie_end", tag), input_enable, 1'b1);
        $display("frame %s byte=%02h checked", tag, b);
    endtask

    initial begin
        int n0;
        rst         = 1'b1;
        input_valid = 1'b0;
        data_in     = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst tx", tx, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", tx_done, 1'b0);
        check("rst ie", input_enable, 1'b0);

        // Idle with no valid: line stays high, ready stays high
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("idle tx %0d", i), tx, 1'b1);
            check($sformatf("idle ie %0d", i), input_enable, 1'b1);
            check($sformatf("idle busy %0d", i), busy, 1'b0);
            @(negedge clk);
        end

        // Single 0xA5 frame; tx_done must be a single cycle
        play_frame("a5", 8'hA5, F_A5, 1'b0, 1'b0);
        @(negedge clk);
        check("a5 done_once", tx_done, 1'b0);

`ifdef UART_TX_PARITY_EN
        play_frame("07", 8'h07, F_07, 1'b0, 1'b0);
        @(negedge clk);
        check("07 done_once", tx_done, 1'b0);
`endif

        // Back-to-back frames with input_valid held high
        n0 = acc_log.size();
        play_frame("b2b00", 8'h00, F_00, 1'b1, 1'b0);
        play_frame("b2bff", 8'hFF, F_FF, 1'b1, 1'b0);
        play_frame("b2b3c", 8'h3C, F_3C, 1'b0, 1'b0);
        check("b2b accepts", 32'(acc_log.size() - n0), 32'd3);
        if (acc_log.size() - n0 == 3) begin
            check("b2b gap1", 32'(acc_log[n0 + 1] - acc_log[n0]), 32'(FRAME + 1));
            check("b2b gap2", 32'(acc_log[n0 + 2] - acc_log[n0 + 1]), 32'(FRAME + 1));
        end
        @(negedge clk);

        // data_in scrambled during the frame must not leak onto tx
        play_frame("5a", 8'h5A, F_5A, 1'b0, 1'b1);
        data_in = 8'h00;
        @(negedge clk);

        // Reset pulse during DATA bit 3 (cycles 17..20 after accept)
        data_in     = 8'hF0;
        input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        data_in     = 8'h00;
        repeat (17) @(negedge clk);
        check("abort bit3 tx", tx, 1'b0);
        check("abort bit3 busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort tx", tx, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort done", tx_done, 1'b0);
        check("abort ie", input_enable, 1'b0);
        rst = 1'b0;
        // Offered on the very first edge after reset release
        play_frame("81", 8'h81, F_81, 1'b0, 1'b0);
        @(negedge clk);
        check("81 done_once", tx_done, 1'b0);
        check("81 idle tx", tx, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
